// File: rtl/mem_rr_arbiter.sv
// Work-conserving round-robin arbiter that multiplexes N PicoRV32 native memory
// ports onto one downstream target port, with an optional hung-target watchdog.

module mem_rr_lane (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [31:0] data,
  output logic        ready,
  output logic [31:0] rdata
);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= load;
      if (load) rdata <= data;
    end
  end
endmodule

module mem_rr_arbiter #(
  parameter int N_CORES = 2,
  parameter int TIMEOUT = 0,
  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_CORES-1:0]      cpu_valid,
  input  logic [32*N_CORES-1:0]   cpu_addr,
  input  logic [32*N_CORES-1:0]   cpu_wdata,
  input  logic [4*N_CORES-1:0]    cpu_wstrb,
  output logic [N_CORES-1:0]      cpu_ready,
  output logic [32*N_CORES-1:0]   cpu_rdata,
  output logic                    tgt_valid,
  output logic [31:0]             tgt_addr,
  output logic [31:0]             tgt_wdata,
  output logic [3:0]              tgt_wstrb,
  output logic [IDX_W-1:0]        tgt_owner,
  input  logic                    tgt_ready,
  input  logic [31:0]             tgt_rdata,
  output logic                    timeout_err
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t                     state, state_nxt;
  logic [IDX_W-1:0]           ptr, ptr_nxt, gnt, hi_g, lo_g;
  logic                       hi_hit, any_req, done, expire;
  logic [CNT_W-1:0]           cnt;
  logic [N_CORES-1:0][31:0]   addr_v, wdata_v, rdata_v;
  logic [N_CORES-1:0][3:0]    wstrb_v;
  logic [31:0]                lane_data;

  assign addr_v    = cpu_addr;
  assign wdata_v   = cpu_wdata;
  assign wstrb_v   = cpu_wstrb;
  assign cpu_rdata = rdata_v;

  // Two descending scans: the last hit is the lowest index, first among those
  // at or above ptr, falling back to the lowest overall (wrap-around).
  always_comb begin
    hi_hit = 1'b0;
    hi_g   = '0;
    lo_g   = '0;
    for (int j = N_CORES - 1; j >= 0; j--) begin
      if (cpu_valid[j]) begin
        lo_g = IDX_W'(j);
        if (IDX_W'(j) >= ptr) begin
          hi_hit = 1'b1;
          hi_g   = IDX_W'(j);
        end
      end
    end
    gnt     = hi_hit ? hi_g : lo_g;
    any_req = |cpu_valid;
  end

  assign ptr_nxt = (tgt_owner == IDX_W'(N_CORES - 1)) ? '0 : tgt_owner + 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    expire    = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (any_req) state_nxt = S_BUSY;
      S_BUSY: begin
        expire = (TIMEOUT != 0) && (cnt == CNT_LAST) && !tgt_ready;
        done   = tgt_ready || expire;
        if (done) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tgt_valid   <= 1'b0;
      tgt_addr    <= '0;
      tgt_wdata   <= '0;
      tgt_wstrb   <= '0;
      tgt_owner   <= '0;
      ptr         <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
      case (state)
        S_IDLE: if (any_req) begin
          tgt_valid <= 1'b1;
          tgt_addr  <= addr_v[gnt];
          tgt_wdata <= wdata_v[gnt];
          tgt_wstrb <= wstrb_v[gnt];
          tgt_owner <= gnt;
          cnt       <= '0;
        end
        S_BUSY: begin
          cnt <= cnt + 1'b1;
          if (done) begin
            tgt_valid <= 1'b0;
            ptr       <= ptr_nxt;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign lane_data = expire ? 32'hFFFF_FFFF : tgt_rdata;

  for (genvar i = 0; i < N_CORES; i++) begin : g_lane
    mem_rr_lane u_lane (
      .clk   (clk),
      .resetn(resetn),
      .load  (done && (tgt_owner == IDX_W'(i))),
      .data  (lane_data),
      .ready (cpu_ready[i]),
      .rdata (rdata_v[i])
    );
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: 4 cores, 8-cycle watchdog.
module tb_mem_rr_arbiter;
  localparam int N = 4;
  logic              clk = 0, resetn = 0;
  logic [N-1:0]      cpu_valid = '0;
  logic [32*N-1:0]   cpu_addr = '0, cpu_wdata = '0;
  logic [4*N-1:0]    cpu_wstrb = '0;
  logic [N-1:0]      cpu_ready;
  logic [32*N-1:0]   cpu_rdata;
  logic              tgt_valid, tgt_ready = 0, timeout_err;
  logic [31:0]       tgt_addr, tgt_wdata, tgt_rdata = '0;
  logic [3:0]        tgt_wstrb;
  logic [1:0]        tgt_owner;
  int tests = 0, fails = 0;

  mem_rr_arbiter #(.N_CORES(N), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .tgt_valid(tgt_valid), .tgt_addr(tgt_addr),
    .tgt_wdata(tgt_wdata), .tgt_wstrb(tgt_wstrb), .tgt_owner(tgt_owner),
    .tgt_ready(tgt_ready), .tgt_rdata(tgt_rdata), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] lane(input int i);
    return cpu_rdata[32*i +: 32];
  endfunction

  task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cpu_addr[32*i +: 32] = a; cpu_wdata[32*i +: 32] = d; cpu_wstrb[4*i +: 4] = s;
  endtask

  task automatic test_reset();
    resetn = 0; tick(); tick(); resetn = 1;
    tests++; if (tgt_valid !== 1'b0) begin fails++; $display("FAIL rst_tgt_valid got %b want 0", tgt_valid); end
    tests++; if (cpu_ready !== 4'b0) begin fails++; $display("FAIL rst_cpu_ready got %b want 0", cpu_ready); end
    tests++; if (cpu_rdata !== '0) begin fails++; $display("FAIL rst_cpu_rdata got %h want 0", cpu_rdata); end
    tests++; if ({tgt_addr, tgt_wdata, tgt_wstrb, tgt_owner, timeout_err} !== '0) begin
      fails++; $display("FAIL rst_tgt_regs got %h/%h/%h/%h/%b want 0", tgt_addr, tgt_wdata, tgt_wstrb, tgt_owner, timeout_err); end
  endtask

  task automatic test_single_read();
    set_lane(0, 32'h0000_0010, 32'h0, 4'h0);
    cpu_valid = 4'b0001; tgt_ready = 1; tgt_rdata = 32'h1234_5678;
    tick();
    tests++; if (tgt_valid !== 1'b1 || tgt_addr !== 32'h10 || tgt_owner !== 2'd0 || tgt_wstrb !== 4'h0) begin
      fails++; $display("FAIL sr_grant got v=%b a=%h o=%0d s=%h want 1/10/0/0", tgt_valid, tgt_addr, tgt_owner, tgt_wstrb); end
    tests++; if (cpu_ready !== 4'b0) begin fails++; $display("FAIL sr_early_ready got %b want 0", cpu_ready); end
    tick();
    tests++; if (cpu_ready !== 4'b0001 || lane(0) !== 32'h1234_5678 || tgt_valid !== 1'b0) begin
      fails++; $display("FAIL sr_resp got r=%b d=%h v=%b want 0001/12345678/0", cpu_ready, lane(0), tgt_valid); end
    cpu_valid = '0; tgt_ready = 0;
    tick();
    tests++; if (cpu_ready !== 4'b0) begin fails++; $display("FAIL sr_pulse got %b want 0", cpu_ready); end
  endtask

  task automatic test_idle_skip();  // ptr is 1 here
    set_lane(3, 32'h0000_0300, 32'h0, 4'h0);
    cpu_valid = 4'b1000; tgt_ready = 1; tgt_rdata = 32'h3333_0003;
    tick();
    tests++; if (tgt_valid !== 1'b1 || tgt_owner !== 2'd3 || tgt_addr !== 32'h300) begin
      fails++; $display("FAIL skip_grant got v=%b o=%0d a=%h want 1/3/300", tgt_valid, tgt_owner, tgt_addr); end
    tick();
    tests++; if (cpu_ready !== 4'b1000 || lane(3) !== 32'h3333_0003) begin
      fails++; $display("FAIL skip_resp got r=%b d=%h want 1000/33330003", cpu_ready, lane(3)); end
    cpu_valid = '0; tgt_ready = 0;
    tick();
  endtask

  task automatic test_round_robin();  // ptr is 0 after the wrap from core 3
    int exp_o [6] = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < N; i++) set_lane(i, 32'h2000_0000 + 32'(i) * 4, 32'h0, 4'h0);
    cpu_valid = 4'b1111; tgt_ready = 1;
    for (int k = 0; k < 6; k++) begin
      tgt_rdata = 32'hC0DE_0000 + 32'(k);
      tick();
      tests++; if (tgt_valid !== 1'b1 || tgt_owner !== 2'(exp_o[k]) || tgt_addr !== 32'h2000_0000 + 32'(exp_o[k]) * 4) begin
        fails++; $display("FAIL rr_grant%0d got v=%b o=%0d a=%h want owner %0d", k, tgt_valid, tgt_owner, tgt_addr, exp_o[k]); end
      tick();
      tests++; if (cpu_ready !== 4'(1 << exp_o[k]) || lane(exp_o[k]) !== 32'hC0DE_0000 + 32'(k)) begin
        fails++; $display("FAIL rr_resp%0d got r=%b d=%h want core %0d", k, cpu_ready, lane(exp_o[k]), exp_o[k]); end
      tick();
      tests++; if (cpu_ready !== 4'b0 || tgt_valid !== 1'b0) begin
        fails++; $display("FAIL rr_gap%0d got r=%b v=%b want 0/0", k, cpu_ready, tgt_valid); end
    end
    cpu_valid = '0; tgt_ready = 0;
  endtask

  task automatic test_wait_states();  // ptr is 2; core 1 wins by wrap-around
    int pulses = 0;
    set_lane(1, 32'h1000_0000, 32'h0000_00A5, 4'b0001);
    cpu_valid = 4'b0010; tgt_ready = 0; tgt_rdata = 32'hDEAD_0001;
    tick();
    for (int c = 1; c <= 6; c++) begin
      tests++; if (tgt_valid !== 1'b1 || tgt_owner !== 2'd1 || tgt_addr !== 32'h1000_0000 || tgt_wdata !== 32'hA5 || tgt_wstrb !== 4'b0001) begin
        fails++; $display("FAIL ws_stable_c%0d got v=%b o=%0d a=%h d=%h s=%b", c, tgt_valid, tgt_owner, tgt_addr, tgt_wdata, tgt_wstrb); end
      if (cpu_ready !== 4'b0) pulses++;
      if (c == 6) tgt_ready = 1;
      tick();
    end
    if (cpu_ready === 4'b0010) pulses++;
    tests++; if (lane(1) !== 32'hDEAD_0001 || timeout_err !== 1'b0) begin
      fails++; $display("FAIL ws_resp got d=%h te=%b want dead0001/0", lane(1), timeout_err); end
    cpu_valid = '0; tgt_ready = 0;
    tick();
    if (cpu_ready !== 4'b0) pulses++;
    tests++; if (pulses != 1) begin fails++; $display("FAIL ws_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_reset_mid();  // ptr is 2
    set_lane(2, 32'h0000_0200, 32'h0, 4'h0);
    set_lane(1, 32'h0000_0100, 32'h0, 4'h0);
    cpu_valid = 4'b0100; tgt_ready = 0;
    tick();
    tests++; if (tgt_owner !== 2'd2 || tgt_valid !== 1'b1) begin
      fails++; $display("FAIL rm_pre got o=%0d v=%b want 2/1", tgt_owner, tgt_valid); end
    tick();
    resetn = 0; cpu_valid = 4'b0110;
    tick();
    resetn = 1;
    tests++; if ({tgt_valid, cpu_ready, timeout_err, tgt_owner} !== '0 || cpu_rdata !== '0 || {tgt_addr, tgt_wdata, tgt_wstrb} !== '0) begin
      fails++; $display("FAIL rm_clear got v=%b r=%b te=%b o=%0d a=%h rd=%h want 0", tgt_valid, cpu_ready, timeout_err, tgt_owner, tgt_addr, cpu_rdata); end
    tgt_ready = 1; tgt_rdata = 32'h0000_0077;
    tick();
    tests++; if (tgt_owner !== 2'd1 || tgt_valid !== 1'b1 || tgt_addr !== 32'h100 || cpu_ready !== 4'b0) begin
      fails++; $display("FAIL rm_regrant got o=%0d v=%b a=%h r=%b want 1/1/100/0", tgt_owner, tgt_valid, tgt_addr, cpu_ready); end
    tick();
    tests++; if (cpu_ready !== 4'b0010 || lane(1) !== 32'h77 || lane(2) !== 32'h0) begin
      fails++; $display("FAIL rm_resp got r=%b d1=%h d2=%h want 0010/77/0", cpu_ready, lane(1), lane(2)); end
    cpu_valid = '0; tgt_ready = 0;
    tick();
  endtask

  task automatic test_watchdog();  // ptr is 2
    cpu_valid = 4'b0100; tgt_ready = 0; tgt_rdata = 32'h0BAD_0BAD;
    tick();
    for (int c = 1; c <= 8; c++) begin
      tests++; if (tgt_valid !== 1'b1 || cpu_ready !== 4'b0 || timeout_err !== 1'b0) begin
        fails++; $display("FAIL wd_busy_c%0d got v=%b r=%b te=%b want 1/0/0", c, tgt_valid, cpu_ready, timeout_err); end
      tick();
    end
    tests++; if (cpu_ready !== 4'b0100 || timeout_err !== 1'b1 || lane(2) !== 32'hFFFF_FFFF || tgt_valid !== 1'b0) begin
      fails++; $display("FAIL wd_expire got r=%b te=%b d=%h v=%b want 0100/1/ffffffff/0", cpu_ready, timeout_err, lane(2), tgt_valid); end
    tests++; if (lane(1) !== 32'h77) begin fails++; $display("FAIL wd_hold got %h want 77", lane(1)); end
    cpu_valid = 4'b1000; set_lane(3, 32'h0000_0330, 32'h0, 4'h0);
    tick();
    tests++; if (cpu_ready !== 4'b0 || timeout_err !== 1'b0) begin
      fails++; $display("FAIL wd_pulse got r=%b te=%b want 0/0", cpu_ready, timeout_err); end
    tgt_ready = 1; tgt_rdata = 32'h0000_0055;
    tick();
    tests++; if (tgt_owner !== 2'd3 || tgt_valid !== 1'b1 || tgt_addr !== 32'h330) begin
      fails++; $display("FAIL wd_next_grant got o=%0d v=%b a=%h want 3/1/330", tgt_owner, tgt_valid, tgt_addr); end
    tick();
    tests++; if (cpu_ready !== 4'b1000 || timeout_err !== 1'b0 || lane(3) !== 32'h55) begin
      fails++; $display("FAIL wd_next_resp got r=%b te=%b d=%h want 1000/0/55", cpu_ready, timeout_err, lane(3)); end
    cpu_valid = '0; tgt_ready = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_idle_skip();
    test_round_robin();
    test_wait_states();
    test_reset_mid();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Parametrised N-core front end for the shared memory/IO bus. It arbitrates the native PicoRV32 memory interfaces of `N_CORES` harts onto one downstream target port. Arbitration is work-conserving round-robin: idle cores are skipped rather than given fixed time slots. Downstream latency is variable, handled by a `tgt_valid`/`tgt_ready` handshake, with an optional watchdog that terminates hung target transactions. The block sits between the core array and the memory/LED/UART decode in the SoC top level.

## Interface
Parameters:
- `N_CORES`, default 2: number of requesters, legal range 1..16.
- `TIMEOUT`, default 0: BUSY cycles before forced termination; 0 disables the watchdog.
- `IDX_W` (localparam): `max(1, $clog2(N_CORES))`.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  reset. One clock; reset is synchronous and active-low.
- `cpu_valid`  in  N_CORES  per-core request.
- `cpu_addr`  in  32*N_CORES  packed byte addresses; lane i occupies bits [32i+31:32i].
- `cpu_wdata`  in  32*N_CORES  packed write data.
- `cpu_wstrb`  in  4*N_CORES  packed byte strobes; 0 means read.
- `cpu_ready`  out  N_CORES  one-cycle completion pulse per core.
- `cpu_rdata`  out  32*N_CORES  packed read data; valid in the cycle `cpu_ready[i]` is high.
- `tgt_valid`  out  1  downstream request.
- `tgt_addr`  out  32  latched address of the granted core.
- `tgt_wdata`  out  32  latched write data.
- `tgt_wstrb`  out  4  latched strobes.
- `tgt_owner`  out  IDX_W  index of the granted core.
- `tgt_ready`  in  1  target completion; sampled only while `tgt_valid` is high.
- `tgt_rdata`  in  32  target read data, valid with `tgt_ready`.
- `timeout_err`  out  1  one-cycle pulse on watchdog termination.

## Operation
- FSM states are IDLE, BUSY and RESP. Reset state is IDLE.
- **Priority pointer:** `ptr` (IDX_W bits) is reset to 0.
- **IDLE:**
  - If any `cpu_valid` is high, grant `g`, the first index at or above `ptr` (modulo `N_CORES`) with `cpu_valid[g]` high.
  - Latch `cpu_addr/wdata/wstrb[g]` into `tgt_*`, set `tgt_owner` to g, set `tgt_valid` to 1, and go to BUSY.
  - If no request is pending, remain in IDLE.
- **BUSY:**
  - `tgt_*` and `tgt_owner` hold stable, and the watchdog counter increments each cycle.
  - On `tgt_ready` = 1:
    - `cpu_rdata` lane g is set to `tgt_rdata`.
    - `cpu_ready[g]` is set to 1.
    - `tgt_valid` is set to 0.
    - `ptr` is set to (g+1) mod `N_CORES`.
    - Go to RESP.
  - On watchdog expiry (`TIMEOUT` != 0, counter == `TIMEOUT`-1, `tgt_ready` low): same as above, but lane g receives 32'hFFFF_FFFF and `timeout_err` is set to 1.
  - `tgt_ready` takes precedence over expiry when both occur in the same cycle.
- **RESP:** exactly one cycle. `cpu_ready[g]` and `timeout_err` are high, then both clear, the counter clears, and the FSM goes to IDLE. The core drops `cpu_valid` in this cycle or the next, so a stale request is never regranted.
- Non-granted `cpu_rdata` lanes hold their previous values.
- Changes on `cpu_valid` of non-granted cores during BUSY or RESP are ignored until the next IDLE.
- `N_CORES` = 1: `ptr` and `tgt_owner` are constant 0, and the FSM is unchanged.
- **Reset:**
  - At the next edge with `resetn` low, the following clear to 0: `cpu_ready`, `cpu_rdata`, `tgt_valid`, `tgt_addr/wdata/wstrb`, `tgt_owner`, `timeout_err`, `ptr` and the counter.
  - Reset mid-BUSY abandons the transaction and no `cpu_ready` is issued.

## Timing
- Request high at edge t with the FSM in IDLE: `tgt_valid` high after edge t.
- `tgt_ready` high during that same cycle: `cpu_ready` high after edge t+1, then low after edge t+2.
- Minimum occupancy is 3 cycles per transaction (IDLE, BUSY, RESP). Each extra target wait cycle adds 1 cycle.
- Worst-case grant wait for a continuously requesting core is `N_CORES`-1 full transactions (starvation-free).
- **Watchdog:** termination occurs after exactly `TIMEOUT` BUSY cycles; `cpu_ready` and `timeout_err` then appear in the following RESP cycle.
- All outputs are registered, with no combinational path from input to output.

## Test plan
- **Single read:** `N_CORES`=2, core 0 reads 0x0000_0010, and the target returns 0x1234_5678 with zero wait. Required: `tgt_valid` at t+1, `cpu_ready[0]` at t+2, lane 0 = 0x1234_5678, `ptr` = 1.
- **Round-robin fairness:** `N_CORES`=4, all cores requesting continuously, zero-wait target. Required grant order 0,1,2,3,0,1 with one grant every 3 cycles; `tgt_owner` matches each grant.
- **Idle skip:** `N_CORES`=4, `ptr`=1, only core 3 requesting. Required: core 3 granted in the first IDLE cycle, `ptr` becomes 0.
- **Wait states and stability:** target holds `tgt_ready` low for 5 cycles, then completes a write (addr 0x1000_0000, wstrb 4'b0001, wdata 0xA5). Required: `tgt_*` stable for all 6 BUSY cycles and exactly one `cpu_ready` pulse.
- **Watchdog:** `TIMEOUT`=8, target never ready. Required: after 8 BUSY cycles, lane g = 0xFFFF_FFFF, `cpu_ready[g]` and `timeout_err` pulse together for 1 cycle, and the next grant proceeds normally.
- **Reset mid-transaction:** `resetn` low for 1 cycle during BUSY. Required: all outputs 0 after that edge, no `cpu_ready` for the abandoned request, and the first post-reset grant goes to the lowest-index requester.
